// File: rtl/rf_writeback_arbiter_if.sv
// ============================================================================
// rf_writeback_arbiter_if : producer / register-file bundle for the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface rf_writeback_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;

    logic            issue_valid;
    logic [4:0]      issue_rd;

    logic            regwrite;
    logic [4:0]      write_register;
    logic [XLEN-1:0] write_data;
    logic [31:0]     pending;
    logic [CW-1:0]   fifo_count;

    // Producer / consumer side (execute, memory return, issue, register file)
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd,
        input  mem_ready,
        input  regwrite, write_register, write_data,
        input  pending, fifo_count
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd,
        output mem_ready,
        output regwrite, write_register, write_data,
        output pending, fifo_count
    );
endinterface

`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
// ============================================================================
// rf_writeback_arbiter : ALU-priority write-port arbiter with slow-path FIFO
//                        and 32-entry pending scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module rf_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    rf_writeback_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // FIFO storage and pointers
    logic [4:0]      rd_mem_q   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    // Register-file write port
    logic            regwrite_q, regwrite_d;
    logic [4:0]      wreg_q, wreg_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [31:0]     pending_q, pending_d;

    logic            w_mem_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_alu_win;
    logic            w_fifo_empty;

    // Readiness depends on occupancy only, so a pop never frees a slot early
    assign w_mem_ready  = rst_n && (count_q != FULL_COUNT);
    assign w_fifo_empty = (count_q == '0);
    assign w_alu_win    = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign w_push       = bus.mem_valid && w_mem_ready && (bus.mem_rd != 5'd0);
    assign w_pop        = !w_alu_win && !w_fifo_empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_push) begin
            tail_d = tail_q + PW'(1);
        end
        if (w_pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(w_push) - CW'(w_pop);
    end

    always_comb begin
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (w_alu_win) begin
            regwrite_d = 1'b1;
            wreg_d     = bus.alu_rd;
            wdata_d    = bus.alu_data;
        end else if (w_pop) begin
            regwrite_d = 1'b1;
            wreg_d     = rd_mem_q[head_q];
            wdata_d    = data_mem_q[head_q];
        end
    end

    // Clear first so a same-cycle re-issue of the popped register wins
    always_comb begin
        pending_d = pending_q;
        if (w_pop) begin
            pending_d[rd_mem_q[head_q]] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            pending_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            pending_q  <= pending_d;
        end
    end

    // Payload storage needs no reset; occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            rd_mem_q[tail_q]   <= bus.mem_rd;
            data_mem_q[tail_q] <= bus.mem_data;
        end
    end

    assign bus.mem_ready      = w_mem_ready;
    assign bus.regwrite       = regwrite_q;
    assign bus.write_register = wreg_q;
    assign bus.write_data     = wdata_q;
    assign bus.pending        = pending_q;
    assign bus.fifo_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
// ============================================================================
// tb_rf_writeback_arbiter : directed scenario bench for rf_writeback_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rf_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    rf_writeback_arbiter_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    rf_writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = 5'd0;
        bus.mem_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_total++;
        if ({bus.regwrite, bus.write_register, bus.write_data} !== 38'd0) $display("FAIL reset_out: got %b/%0d/%h want 0", bus.regwrite, bus.write_register, bus.write_data);
        else n_pass++;
        n_total++;
        if (bus.mem_ready !== 1'b0) $display("FAIL reset_mem_ready: got %b want 0", bus.mem_ready);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        // Fill 3 entries while the ALU holds the port
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd11;
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(11 + i); bus.mem_data = 32'(i);
            tick();
        end
        n_total++;
        if (bus.fifo_count !== 3'd3) $display("FAIL reset_prefill_count: got %0d want 3", bus.fifo_count);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.regwrite !== 1'b0 || bus.write_register !== 5'd0 || bus.write_data !== 32'd0) $display("FAIL reset_mid_out: got %b/%0d/%h want 0/0/0", bus.regwrite, bus.write_register, bus.write_data);
        else n_pass++;
        n_total++;
        if (bus.fifo_count !== 3'd0 || bus.pending !== 32'd0) $display("FAIL reset_mid_state: got count %0d pending %h want 0/0", bus.fifo_count, bus.pending);
        else n_pass++;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (bus.regwrite !== 1'b0 || bus.fifo_count !== 3'd0) $display("FAIL reset_no_drain: cycle %0d got regwrite %b count %0d want 0/0", i, bus.regwrite, bus.fifo_count);
            else n_pass++;
        end
        n_total++;
        if (bus.mem_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.mem_ready);
        else n_pass++;
    endtask

    task automatic test_priority();
        idle_inputs();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'hAAAA0005;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7;
        tick();
        n_total++;
        if (bus.regwrite !== 1'b1 || bus.write_register !== 5'd7 || bus.write_data !== 32'h7 || bus.fifo_count !== 3'd1) $display("FAIL prio_alu1: got %b/%0d/%h cnt %0d want 1/7/7 cnt 1", bus.regwrite, bus.write_register, bus.write_data, bus.fifo_count);
        else n_pass++;
        bus.mem_valid = 1'b0;
        tick();
        n_total++;
        if (bus.regwrite !== 1'b1 || bus.write_register !== 5'd7 || bus.fifo_count !== 3'd1) $display("FAIL prio_alu2: got %b/%0d cnt %0d want 1/7 cnt 1", bus.regwrite, bus.write_register, bus.fifo_count);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (bus.regwrite !== 1'b1 || bus.write_register !== 5'd5 || bus.write_data !== 32'hAAAA0005 || bus.fifo_count !== 3'd0) $display("FAIL prio_mem: got %b/%0d/%h cnt %0d want 1/5/aaaa0005 cnt 0", bus.regwrite, bus.write_register, bus.write_data, bus.fifo_count);
        else n_pass++;
        tick();
        n_total++;
        if (bus.regwrite !== 1'b0 || bus.write_register !== 5'd5) $display("FAIL prio_idle_hold: got %b/%0d want 0/5", bus.regwrite, bus.write_register);
        else n_pass++;
    endtask

    task automatic test_full();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h20;
        for (int i = 1; i <= 4; i++) begin
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(i); bus.mem_data = 32'h100 + 32'(i);
            n_total++;
            if (bus.mem_ready !== 1'b1) $display("FAIL full_ready_%0d: got %b want 1", i, bus.mem_ready);
            else n_pass++;
            tick();
        end
        n_total++;
        if (bus.mem_ready !== 1'b0 || bus.fifo_count !== 3'd4) $display("FAIL full_state: got ready %b count %0d want 0/4", bus.mem_ready, bus.fifo_count);
        else n_pass++;
        bus.mem_rd = 5'd25; bus.mem_data = 32'hBAD;
        tick();
        n_total++;
        if (bus.fifo_count !== 3'd4 || bus.write_register !== 5'd20) $display("FAIL full_reject: got count %0d wr %0d want 4/20", bus.fifo_count, bus.write_register);
        else n_pass++;
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_total++;
            if (bus.regwrite !== 1'b1 || bus.write_register !== 5'(i) || bus.write_data !== 32'h100 + 32'(i) || bus.fifo_count !== 3'(4 - i) || bus.mem_ready !== 1'b1)
                $display("FAIL full_drain_%0d: got %b/%0d/%h cnt %0d rdy %b want 1/%0d/%h cnt %0d rdy 1", i, bus.regwrite, bus.write_register, bus.write_data, bus.fifo_count, bus.mem_ready, i, 32'h100 + 32'(i), 4 - i);
            else n_pass++;
        end
        tick();
        n_total++;
        if (bus.regwrite !== 1'b0) $display("FAIL full_after: got regwrite %b want 0", bus.regwrite);
        else n_pass++;
    endtask

    task automatic test_wrap();
        idle_inputs();
        for (int i = 1; i <= 10; i++) begin
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(i); bus.mem_data = 32'(i * 32'h11);
            tick();
            n_total++;
            if (bus.fifo_count !== 3'd1) $display("FAIL wrap_count_%0d: got %0d want 1", i, bus.fifo_count);
            else n_pass++;
            if (i > 1) begin
                n_total++;
                if (bus.regwrite !== 1'b1 || bus.write_register !== 5'(i - 1) || bus.write_data !== 32'((i - 1) * 32'h11))
                    $display("FAIL wrap_write_%0d: got %b/%0d/%h want 1/%0d/%h", i - 1, bus.regwrite, bus.write_register, bus.write_data, i - 1, (i - 1) * 32'h11);
                else n_pass++;
            end else begin
                n_total++;
                if (bus.regwrite !== 1'b0) $display("FAIL wrap_first_latency: got regwrite %b want 0", bus.regwrite);
                else n_pass++;
            end
        end
        idle_inputs();
        tick();
        n_total++;
        if (bus.regwrite !== 1'b1 || bus.write_register !== 5'd10 || bus.write_data !== 32'hAA || bus.fifo_count !== 3'd0)
            $display("FAIL wrap_last: got %b/%0d/%h cnt %0d want 1/10/aa cnt 0", bus.regwrite, bus.write_register, bus.write_data, bus.fifo_count);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        tick();
        n_total++;
        if (bus.pending !== 32'h0000_0200) $display("FAIL sb_set: got %h want 00000200", bus.pending);
        else n_pass++;
        idle_inputs();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        tick();
        n_total++;
        if (bus.pending[9] !== 1'b1 || bus.regwrite !== 1'b0) $display("FAIL sb_wait: got pending9 %b regwrite %b want 1/0", bus.pending[9], bus.regwrite);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (bus.regwrite !== 1'b1 || bus.write_register !== 5'd9 || bus.write_data !== 32'h99 || bus.pending !== 32'd0)
            $display("FAIL sb_clear: got %b/%0d/%h pending %h want 1/9/99 pending 0", bus.regwrite, bus.write_register, bus.write_data, bus.pending);
        else n_pass++;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        tick();
        idle_inputs();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        tick();
        idle_inputs();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        tick();
        n_total++;
        if (bus.regwrite !== 1'b1 || bus.write_register !== 5'd9 || bus.pending !== 32'h0000_0200)
            $display("FAIL sb_set_wins: got %b/%0d pending %h want 1/9 pending 00000200", bus.regwrite, bus.write_register, bus.pending);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (bus.pending[9] !== 1'b1) $display("FAIL sb_still_set: got %b want 1", bus.pending[9]);
        else n_pass++;
    endtask

    task automatic test_x0();
        idle_inputs();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h33;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd21; bus.alu_data = 32'h21;
        tick();
        n_total++;
        if (bus.fifo_count !== 3'd1 || bus.write_register !== 5'd21 || bus.pending[0] !== 1'b0) $display("FAIL x0_setup: got cnt %0d wr %0d p0 %b want 1/21/0", bus.fifo_count, bus.write_register, bus.pending[0]);
        else n_pass++;
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
        tick();
        n_total++;
        if (bus.regwrite !== 1'b1 || bus.write_register !== 5'd3 || bus.write_data !== 32'h33 || bus.fifo_count !== 3'd0)
            $display("FAIL x0_alu: got %b/%0d/%h cnt %0d want 1/3/33 cnt 0", bus.regwrite, bus.write_register, bus.write_data, bus.fifo_count);
        else n_pass++;
        idle_inputs();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hBEEF;
        n_total++;
        if (bus.mem_ready !== 1'b1) $display("FAIL x0_mem_ready: got %b want 1", bus.mem_ready);
        else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (bus.fifo_count !== 3'd0 || bus.regwrite !== 1'b0 || bus.write_register !== 5'd3) $display("FAIL x0_mem_push: got cnt %0d regwrite %b wr %0d want 0/0/3", bus.fifo_count, bus.regwrite, bus.write_register);
        else n_pass++;
        tick();
        n_total++;
        if (bus.regwrite !== 1'b0 || bus.write_data !== 32'h33) $display("FAIL x0_no_write: got %b/%h want 0/33", bus.regwrite, bus.write_data);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        idle_inputs();
        test_reset();
        test_priority();
        test_full();
        test_wrap();
        test_scoreboard();
        test_x0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion want finish before 100000");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Drives the register file's single write port (`regwrite`, `write_register`, `write_data`) from two producers. The first producer is the single-cycle ALU result path, which has priority and no backpressure. The second is a slow memory/load return path, buffered in a small FIFO with a valid/ready handshake. The block also keeps a 32-entry pending scoreboard so issue logic can tell when an architectural register is awaiting a slow-path result. It sits between the execute/memory return paths and the register file.

## Interface
- `DEPTH`, 4: slow-path FIFO entries. Must be a power of 2 and ≥ 2.
- `XLEN`, 32: data width.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `alu_valid` input 1: ALU result valid this cycle.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input XLEN: ALU result.
- `mem_valid` input 1: slow-path result offered.
- `mem_ready` output 1: FIFO can accept. Combinational: `rst_n && count != DEPTH`.
- `mem_rd` input 5: slow-path destination register.
- `mem_data` input XLEN: slow-path result.
- `issue_valid` input 1: a slow-path instruction issues this cycle.
- `issue_rd` input 5: its destination register.
- `regwrite` output 1: registered write enable to the register file.
- `write_register` output 5: registered write address.
- `write_data` output XLEN: registered write data.
- `pending` output 32: scoreboard; bit r = 1 means register r awaits a slow-path write.
- `fifo_count` output $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- **Reset.** Applies asynchronously. Values while `rst_n` = 0:
  - `regwrite` = 0, `write_register` = 0, `write_data` = 0.
  - `pending` = 0, FIFO empty, `fifo_count` = 0.
  - `mem_ready` = 0.
- **Reset mid-operation.** All buffered entries and pending bits are discarded. The bench must not expect the FIFO to drain.
- **Accept.**
  - A slow-path handshake occurs when `mem_valid && mem_ready` at a rising edge.
  - If `mem_rd` != 0, the entry {`mem_rd`, `mem_data`} is pushed at the tail.
  - If `mem_rd` == 0, the handshake completes but nothing is pushed.
- **Grant, evaluated per cycle:**
  - `alu_valid && alu_rd != 0`: ALU wins. Output registers load {1, `alu_rd`, `alu_data`}. No pop.
  - Otherwise, if the FIFO is non-empty: pop the head. Output registers load {1, head.rd, head.data}.
  - Otherwise: `regwrite` loads 0; `write_register` and `write_data` hold their previous values.
- **ALU writes to rd = 0** are ignored completely. The FIFO may pop in that same cycle.
- **Push and pop in the same cycle** is allowed. Occupancy is unchanged, and FIFO order is preserved.
  - Because `mem_ready` depends only on occupancy, a full FIFO never accepts, even when a pop occurs that cycle.
  - A pushed entry is never popped in the cycle it is pushed; there is no bypass.
- **FIFO storage.** Circular buffer with head and tail pointers that wrap modulo DEPTH.
- **Scoreboard:**
  - Set: `issue_valid && issue_rd != 0` sets `pending[issue_rd]` at the edge.
  - Clear: a FIFO pop clears `pending[head.rd]` at the same edge the output registers load.
  - Set and clear of the same register in one cycle: set wins.
  - `pending[0]` is constant 0.
  - ALU writes never touch the scoreboard.
- **No starvation guard.** Continuous ALU traffic stalls the FIFO indefinitely; backpressure reaches the slow path through `mem_ready`.

## Timing
- **ALU path latency 1.**
  - `alu_valid` sampled at edge k → `regwrite` high during cycle k..k+1.
  - The register file commits at edge k+1.
- **Slow path latency ≥ 2.**
  - Handshake at edge k → earliest pop at edge k+1.
  - `regwrite` high during cycle k+1..k+2.
  - The write commits at edge k+2.
  - Each cycle the ALU wins adds 1.
- **Throughput.** At most one register-file write per cycle. FIFO sustains 1 push and 1 pop per cycle.
- **`fifo_count`** updates at the same edge as the push/pop.
- **`pending[r]`:**
  - Rises one cycle after issue.
  - Falls in the same cycle `regwrite` goes high for that slow-path result.

## Test plan
- **Reset.**
  - Stimulus: hold `rst_n` = 0 mid-traffic with the FIFO holding 3 entries, then release.
  - Required: outputs are 0, `fifo_count` = 0, `pending` = 0, and no `regwrite` occurs afterwards.
- **Priority.**
  - Stimulus: FIFO holds {rd 5, 0xAAAA0005}; drive `alu_valid` with rd 7 / 0x7 for 2 cycles, then idle.
  - Required: writes appear in order rd 7, rd 7, rd 5; rd 5 appears 1 cycle after the ALU stops.
- **Full/backpressure.**
  - Stimulus: `alu_valid` held high; push 4 entries rd 1..4.
  - Required: `mem_ready` = 0 with `fifo_count` = 4; after `alu_valid` drops, writes rd 1, 2, 3, 4 occur on consecutive cycles and `mem_ready` returns to 1.
- **Wrap-around.**
  - Stimulus: stream 10 entries (rd 1..10, data = rd×0x11) with no ALU traffic.
  - Required: 10 writes in order with correct data, each at 2-cycle latency, and `fifo_count` never exceeding 1.
- **Scoreboard.**
  - Stimulus: issue rd 9, then push mem rd 9 / 0x99.
  - Required: `pending[9]` = 1 until the cycle `regwrite` shows rd 9 / 0x99, then 0.
  - Stimulus: same-cycle re-issue of rd 9 together with the pop.
  - Required: `pending[9]` stays 1.
- **x0 handling.**
  - Stimulus: ALU rd 0 coincident with FIFO head rd 3; and mem rd 0 pushed.
  - Required: rd 3 writes that cycle; mem rd 0 handshakes with `fifo_count` unchanged and no `regwrite`.
